// File: rtl/mil_std_csr_fifo.sv
// mil_std_csr_fifo: MIL-STD-1553 CSR block with RX/TX word FIFOs, burst-send engine and combined IRQ
module mil_std_csr_fifo #(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] amm_address_i,
  input  logic              amm_read_i,
  input  logic              amm_write_i,
  input  logic [15:0]       amm_writedata_i,
  output logic [15:0]       amm_readdata_o,
  input  logic [15:0]       rx_data_i,
  input  logic              rx_sync_c_i,
  input  logic              rx_parity_err_i,
  input  logic              rx_valid_i,
  input  logic              rx_busy_i,
  output logic              rx_en_o,
  output logic [15:0]       tx_data_o,
  output logic              tx_sync_c_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic              tx_busy_i,
  output logic              tx_en_o,
  output logic              irq_o
);
  localparam int RA = $clog2(RX_DEPTH);
  localparam int TA = $clog2(TX_DEPTH);
  localparam int L = RA + 1;
  localparam int T = TA + 1;
  typedef enum logic [1:0] {IDLE, DRAIN, WAIT} state_t;
  state_t state, state_n;
  logic [17:0] rx_mem [RX_DEPTH];
  logic [16:0] tx_mem [TX_DEPTH];
  logic [RA-1:0] rx_wp, rx_rp;
  logic [TA-1:0] tx_wp, tx_rp;
  logic [L-1:0] rx_lvl;
  logic [T-1:0] tx_lvl;
  logic rcv_en, rcv_ie, xmt_en, xmt_ie, xmt_sync, trs;
  logic [1:0] rx_vec, rx_vec_n;
  logic [31:0] a;
  logic [15:0] wd, rdata;
  logic [17:0] rx_head;
  logic [16:0] tx_head;
  logic wr0, wr1, wr5, wr6, wr8;
  logic rx_empty, rx_full, rx_pop, rx_push, rx_ovf;
  logic tx_empty, tx_full, tx_pop, tx_push;
  logic xmt_clr, send, trs_set, trs_n, rcv_ie_n, xmt_ie_n;
  assign a = 32'(amm_address_i);
  assign wd = amm_writedata_i;
  assign wr0 = amm_write_i && a == 0;
  assign wr1 = amm_write_i && a == 1;
  assign wr5 = amm_write_i && a == 5;
  assign wr6 = amm_write_i && a == 6;
  assign wr8 = amm_write_i && a == 8;
  assign rx_empty = rx_lvl == '0;
  assign rx_full = rx_lvl == L'(RX_DEPTH);
  assign rx_pop = amm_read_i && a == 2 && !rx_empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the word
  assign rx_push = rx_valid_i && rcv_en && (!rx_full || rx_pop);
  assign rx_ovf = rx_valid_i && rcv_en && rx_full && !rx_pop;
  assign rx_head = rx_empty ? '0 : rx_mem[rx_rp];
  assign tx_empty = tx_lvl == '0;
  assign tx_full = tx_lvl == T'(TX_DEPTH);
  assign tx_head = tx_mem[tx_rp];
  assign tx_valid_o = state == DRAIN;
  assign tx_data_o = tx_valid_o ? tx_head[15:0] : '0;
  assign tx_sync_c_o = tx_valid_o && tx_head[16];
  assign tx_pop = tx_valid_o && tx_ready_i;
  assign tx_push = amm_write_i && a == 7 && !tx_full;
  assign xmt_clr = wr5 && !wd[0];
  assign send = wr5 && wd[0] && wd[2];
  assign rx_en_o = rcv_en;
  assign tx_en_o = xmt_en;
  assign rx_vec_n = (rx_vec & ~(wr1 ? wd[1:0] : 2'b00)) | {rx_ovf, rx_push};
  assign trs_n = (trs && !(wr6 && wd[0])) || trs_set;
  assign rcv_ie_n = wr0 ? wd[1] : rcv_ie;
  assign xmt_ie_n = wr5 ? wd[1] : xmt_ie;
  always_comb begin
    state_n = state;
    trs_set = 1'b0;
    if (xmt_clr) state_n = IDLE;
    else case (state)
      IDLE: if (send) begin
        state_n = tx_empty ? IDLE : DRAIN;
        trs_set = tx_empty;
      end
      DRAIN: if (tx_pop && tx_lvl == T'(1) && !tx_push) state_n = WAIT;
      WAIT: if (!tx_busy_i) begin
        state_n = IDLE;
        trs_set = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    rdata = '0;
    case (a)
      0: rdata = {rx_busy_i || !rx_empty, 13'd0, rcv_ie, rcv_en};
      1: rdata = {14'd0, rx_vec};
      2: rdata = rx_head[15:0];
      3: rdata = 16'({rx_lvl, 8'd0}) | {15'd0, rx_head[16]};
      4: rdata = {15'd0, rx_head[17]};
      5: rdata = {state != IDLE || tx_busy_i, 12'd0, state != IDLE, xmt_ie, xmt_en};
      6: rdata = {15'd0, trs};
      8: rdata = 16'({tx_lvl, 8'd0}) | {15'd0, xmt_sync};
      default: rdata = '0;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wp] <= {rx_parity_err_i, rx_sync_c_i, rx_data_i};
    if (tx_push) tx_mem[tx_wp] <= {xmt_sync, wd};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      rx_wp <= '0;
      rx_rp <= '0;
      rx_lvl <= '0;
      tx_wp <= '0;
      tx_rp <= '0;
      tx_lvl <= '0;
      rcv_en <= 1'b0;
      rcv_ie <= 1'b0;
      xmt_en <= 1'b0;
      xmt_ie <= 1'b0;
      xmt_sync <= 1'b0;
      rx_vec <= '0;
      trs <= 1'b0;
      amm_readdata_o <= '0;
      irq_o <= 1'b0;
    end else begin
      state <= state_n;
      rx_wp <= rx_wp + RA'(rx_push);
      rx_rp <= rx_rp + RA'(rx_pop);
      rx_lvl <= rx_lvl + L'(rx_push) - L'(rx_pop);
      tx_wp <= xmt_clr ? '0 : tx_wp + TA'(tx_push);
      tx_rp <= xmt_clr ? '0 : tx_rp + TA'(tx_pop);
      tx_lvl <= xmt_clr ? '0 : tx_lvl + T'(tx_push) - T'(tx_pop);
      rcv_en <= wr0 ? wd[0] : rcv_en;
      rcv_ie <= rcv_ie_n;
      xmt_en <= wr5 ? wd[0] : xmt_en;
      xmt_ie <= xmt_ie_n;
      xmt_sync <= wr8 ? wd[0] : xmt_sync;
      rx_vec <= rx_vec_n;
      trs <= trs_n;
      amm_readdata_o <= amm_read_i ? rdata : amm_readdata_o;
      irq_o <= (rcv_ie_n && |rx_vec_n) || (xmt_ie_n && trs_n);
    end
  end
endmodule

// File: tb/tb_mil_std_csr_fifo.sv
// tb_mil_std_csr_fifo: queue-based reference model, directed test-plan checks and random traffic
module tb_mil_std_csr_fifo;
  localparam int RXD = 4;
  localparam int TXD = 4;
  logic clk = 0, rst = 1;
  logic [3:0] amm_address = '0;
  logic amm_read = 0, amm_write = 0;
  logic [15:0] amm_writedata = '0, amm_readdata;
  logic [15:0] rx_data = '0;
  logic rx_sync_c = 0, rx_parity_err = 0, rx_valid = 0, rx_busy = 0, rx_en;
  logic [15:0] tx_data;
  logic tx_sync_c, tx_valid, tx_ready = 0, tx_busy = 0, tx_en, irq;
  int checks = 0, failures = 0;
  logic [17:0] rxq[$];
  logic [16:0] txq[$];
  logic m_rcv_en, m_rcv_ie, m_xmt_en, m_xmt_ie, m_sync, m_trs, m_irq;
  logic [1:0] m_vec;
  logic [15:0] m_rdata;
  int m_st;
  mil_std_csr_fifo #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .ADDR_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .amm_address_i(amm_address), .amm_read_i(amm_read),
    .amm_write_i(amm_write), .amm_writedata_i(amm_writedata), .amm_readdata_o(amm_readdata),
    .rx_data_i(rx_data), .rx_sync_c_i(rx_sync_c), .rx_parity_err_i(rx_parity_err),
    .rx_valid_i(rx_valid), .rx_busy_i(rx_busy), .rx_en_o(rx_en), .tx_data_o(tx_data),
    .tx_sync_c_o(tx_sync_c), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_busy_i(tx_busy),
    .tx_en_o(tx_en), .irq_o(irq));
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] model_read(int a);
    logic [17:0] h;
    h = rxq.size() > 0 ? rxq[0] : 18'd0;
    case (a)
      0: return {rx_busy || rxq.size() > 0, 13'd0, m_rcv_ie, m_rcv_en};
      1: return {14'd0, m_vec};
      2: return h[15:0];
      3: return 16'(rxq.size() * 256) | {15'd0, h[16]};
      4: return {15'd0, h[17]};
      5: return {m_st != 0 || tx_busy, 12'd0, m_st != 0, m_xmt_ie, m_xmt_en};
      6: return {15'd0, m_trs};
      8: return 16'(txq.size() * 256) | {15'd0, m_sync};
      default: return 16'd0;
    endcase
  endfunction
  // one clock: advance the model from the sampled inputs, then compare all outputs
  task automatic step();
    int a;
    logic [15:0] d;
    bit set_rcv, set_ovf, set_trs, tx_was_full;
    @(posedge clk);
    a = int'(amm_address);
    d = amm_writedata;
    set_rcv = 0;
    set_ovf = 0;
    set_trs = 0;
    if (rst) begin
      rxq.delete();
      txq.delete();
      {m_rcv_en, m_rcv_ie, m_xmt_en, m_xmt_ie, m_sync, m_trs, m_irq} = '0;
      m_vec = '0;
      m_rdata = '0;
      m_st = 0;
    end else begin
      tx_was_full = txq.size() == TXD;
      if (amm_read) m_rdata = model_read(a);
      if (amm_read && a == 2 && rxq.size() > 0) void'(rxq.pop_front());
      if (rx_valid && m_rcv_en) begin
        if (rxq.size() < RXD) begin
          rxq.push_back({rx_parity_err, rx_sync_c, rx_data});
          set_rcv = 1;
        end else set_ovf = 1;
      end
      if (m_st == 1 && tx_ready) void'(txq.pop_front());
      if (amm_write && a == 7 && !tx_was_full) txq.push_back({m_sync, d});
      if (amm_write && a == 5 && !d[0]) begin
        txq.delete();
        m_st = 0;
      end else if (m_st == 0 && amm_write && a == 5 && d[0] && d[2]) begin
        if (txq.size() == 0) set_trs = 1;
        else m_st = 1;
      end else if (m_st == 1 && txq.size() == 0) m_st = 2;
      else if (m_st == 2 && !tx_busy) begin
        m_st = 0;
        set_trs = 1;
      end
      if (amm_write && a == 1) m_vec = m_vec & ~d[1:0];
      if (amm_write && a == 6 && d[0]) m_trs = 0;
      m_vec = m_vec | {set_ovf, set_rcv};
      if (set_trs) m_trs = 1;
      if (amm_write && a == 0) {m_rcv_ie, m_rcv_en} = d[1:0];
      if (amm_write && a == 5) {m_xmt_ie, m_xmt_en} = d[1:0];
      if (amm_write && a == 8) m_sync = d[0];
      m_irq = (m_rcv_ie && m_vec != 0) || (m_xmt_ie && m_trs);
    end
    #1;
    chk("readdata", amm_readdata, m_rdata);
    chk("irq", irq, m_irq);
    chk("rx_en", rx_en, m_rcv_en);
    chk("tx_en", tx_en, m_xmt_en);
    chk("tx_valid", tx_valid, m_st == 1);
    if (m_st == 1 && txq.size() > 0) begin
      chk("tx_data", tx_data, txq[0][15:0]);
      chk("tx_sync", tx_sync_c, txq[0][16]);
    end
  endtask
  task automatic bus_wr(int a, logic [15:0] d);
    amm_address = 4'(a);
    amm_writedata = d;
    amm_write = 1;
    step();
    amm_write = 0;
  endtask
  task automatic bus_rd(int a, logic [15:0] exp, string nm);
    amm_address = 4'(a);
    amm_read = 1;
    step();
    amm_read = 0;
    chk(nm, amm_readdata, exp);
  endtask
  task automatic rx_word(logic [15:0] d, logic s, logic p);
    rx_data = d;
    rx_sync_c = s;
    rx_parity_err = p;
    rx_valid = 1;
    step();
    rx_valid = 0;
  endtask
  initial begin
    step();
    step();
    rst = 0;
    chk("rst_readdata", amm_readdata, 16'h0);
    chk("rst_irq", irq, 0);
    bus_rd(0, 16'h0000, "rcv_ctrl_rst");
    bus_wr(0, 16'h0003);
    rx_word(16'h1111, 1, 0);
    rx_word(16'h2222, 0, 1);
    rx_word(16'h3333, 0, 0);
    bus_rd(3, 16'h0301, "rx_status_lvl3");
    bus_rd(4, 16'h0000, "rx_err_head1");
    bus_rd(2, 16'h1111, "rx_pop1");
    bus_rd(4, 16'h0001, "rx_err_head2");
    bus_rd(2, 16'h2222, "rx_pop2");
    bus_rd(2, 16'h3333, "rx_pop3");
    bus_rd(3, 16'h0000, "rx_status_empty");
    bus_rd(2, 16'h0000, "rx_pop_empty");
    chk("irq_rcv", irq, 1);
    bus_wr(1, 16'h0003);
    chk("irq_cleared", irq, 0);
    for (int i = 1; i <= 5; i++) rx_word(16'hB000 + 16'(i), 0, 0);
    bus_rd(1, 16'h0003, "ovf_vec");
    bus_wr(1, 16'h0002);
    bus_rd(1, 16'h0001, "ovf_w1c");
    chk("irq_ovf_en", irq, 1);
    bus_wr(0, 16'h0001);
    chk("irq_masked", irq, 0);
    bus_wr(1, 16'h0003);
    bus_wr(0, 16'h0003);
    amm_address = 4'd2;
    amm_read = 1;
    rx_data = 16'h4444;
    rx_valid = 1;
    step();
    amm_read = 0;
    rx_valid = 0;
    chk("full_pop_push", amm_readdata, 16'hB001);
    bus_rd(3, 16'h0400, "full_level_kept");
    bus_rd(1, 16'h0001, "full_no_ovf");
    bus_rd(2, 16'hB002, "rx_pop_b2");
    bus_rd(2, 16'hB003, "rx_pop_b3");
    bus_rd(2, 16'hB004, "rx_pop_b4");
    bus_rd(2, 16'h4444, "rx_pop_last");
    bus_wr(1, 16'h0003);
    bus_wr(5, 16'h0003);
    bus_wr(8, 16'h0001);
    bus_wr(7, 16'hA5A5);
    bus_wr(8, 16'h0000);
    bus_wr(7, 16'h5A5A);
    bus_rd(8, 16'h0200, "tx_level2");
    bus_wr(5, 16'h0007);
    repeat (3) step();
    chk("tx_stall_valid", tx_valid, 1);
    chk("tx_stall_data", tx_data, 16'hA5A5);
    chk("tx_stall_sync", tx_sync_c, 1);
    tx_ready = 1;
    step();
    chk("tx_second", tx_data, 16'h5A5A);
    chk("tx_second_sync", tx_sync_c, 0);
    tx_busy = 1;
    step();
    tx_ready = 0;
    chk("tx_drained", tx_valid, 0);
    step();
    chk("irq_wait", irq, 0);
    tx_busy = 0;
    step();
    chk("irq_trs", irq, 1);
    bus_rd(6, 16'h0001, "trs_set");
    bus_wr(6, 16'h0001);
    bus_wr(7, 16'h0001);
    bus_wr(7, 16'h0002);
    bus_wr(7, 16'h0003);
    bus_wr(5, 16'h0007);
    tx_ready = 1;
    step();
    tx_ready = 0;
    bus_wr(5, 16'h0002);
    chk("flush_valid", tx_valid, 0);
    bus_rd(8, 16'h0000, "flush_level");
    bus_rd(6, 16'h0000, "flush_no_trs");
    bus_wr(0, 16'h0003);
    rx_word(16'hC001, 0, 0);
    rx_word(16'hC002, 0, 0);
    bus_wr(5, 16'h0003);
    bus_wr(7, 16'h0011);
    bus_wr(7, 16'h0022);
    bus_wr(5, 16'h0007);
    rst = 1;
    step();
    rst = 0;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_en", rx_en, 0);
    chk("rst_irq2", irq, 0);
    bus_rd(3, 16'h0000, "rst_rx_level");
    bus_rd(5, 16'h0000, "rst_xmt_ctrl");
    bus_wr(0, 16'h0003);
    bus_wr(5, 16'h0003);
    for (int n = 0; n < 3000; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      rx_valid = $urandom_range(0, 3) == 0;
      rx_data = 16'($urandom);
      rx_sync_c = 1'($urandom);
      rx_parity_err = 1'($urandom);
      rx_busy = 1'($urandom);
      tx_busy = $urandom_range(0, 2) == 0;
      tx_ready = 1'($urandom);
      amm_read = op < 4;
      amm_write = op >= 4 && op < 8;
      amm_address = amm_read ? ($urandom_range(0, 1) ? 4'd2 : 4'($urandom_range(0, 10)))
                             : ($urandom_range(0, 1) ? 4'd7 : 4'($urandom_range(0, 10)));
      amm_writedata = 16'($urandom);
      if (amm_address == 4'd0 || amm_address == 4'd5) amm_writedata[0] = $urandom_range(0, 7) != 0;
      step();
    end
    amm_read = 0;
    amm_write = 0;
    rx_valid = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
